// File: rtl/alu_serial_sequencer.sv
// alu_serial_sequencer: bit-serial ADD/SUB/XOR/SLT driver for an external combinational 1-bit slice,
// LSB first, with the carry chained through a register and carry/overflow/zero flags at completion.
module alu_serial_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [2:0]       Cntrl,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero,
  output logic             SliceA,
  output logic             SliceB,
  output logic             SliceCin,
  output logic [2:0]       SliceCntrl,
  input  logic             SliceOut,
  input  logic             SliceCout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_nxt;
  logic [CNT_W-1:0] count;
  logic [1:0] op;
  logic carry, accept, last, slt_bit;
  assign accept = (state == IDLE) && Start && !Cntrl[2];
  assign last = (state == RUN) && (count == CNT_W'(WIDTH - 1));
  // SLT sign is the MSB sum corrected by the MSB overflow
  assign slt_bit = SliceOut ^ SliceCin ^ SliceCout;
  assign res_nxt = (last && op == 2'b11) ? {{(WIDTH-1){1'b0}}, slt_bit} : {SliceOut, Result[WIDTH-1:1]};
  assign SliceA = a_sr[0];
  assign SliceB = b_sr[0];
  assign SliceCin = carry;
  assign SliceCntrl = op[0] ? 3'b001 : {1'b0, op};
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = accept ? RUN : IDLE;
      RUN: state_nxt = last ? DONE : RUN;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    Busy = state == RUN;
    Done = state == DONE;
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      op <= '0;
      carry <= 1'b0;
      count <= '0;
      Result <= '0;
      CarryOut <= 1'b0;
      Overflow <= 1'b0;
      Zero <= 1'b0;
    end else if (accept) begin
      a_sr <= OpA;
      b_sr <= OpB;
      op <= Cntrl[1:0];
      carry <= Cntrl[0];
      count <= '0;
      Result <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      carry <= SliceCout;
      count <= last ? count : count + CNT_W'(1);
      Result <= res_nxt;
      if (last) begin
        CarryOut <= ~op[1] & SliceCout;
        Overflow <= ~op[1] & (SliceCin ^ SliceCout);
        Zero <= res_nxt == '0;
      end
    end
endmodule
